write_back_stage: RTL and testbench
===================================

WRITE_BACK_STAGE -- requirements
Module: write_back_stage

Interface
REQ-001 Parameter DATA_W, default 16: datapath width in bits, even, at least 8.
REQ-002 Parameter RADDR_W, default 3: register-file address width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all buffered write-backs.
REQ-006 in_valid  input  1  MEM stage presents a result.
REQ-007 in_ready  output  1  stage accepts a result this cycle.
REQ-008 in_sel  input  2  source select: 0 ALU, 1 DM, 2 LINK, 3 none.
REQ-009 in_alu / in_dm / in_link  input  DATA_W each  candidate results.
REQ-010 in_rd  input  RADDR_W  destination register.
REQ-011 in_byte, in_bsigned, in_blsb  input  1 each  byte-load request, sign-extend, byte select.
REQ-012 rf_ready  input  1  register-file write port free this cycle.
REQ-013 wb_valid  output  1  head entry present.
REQ-014 wb_we  output  1  write strobe: wb_valid and rf_ready and head writes a nonzero register.
REQ-015 wb_addr  output  RADDR_W  head destination.
REQ-016 wb_data  output  DATA_W  head data (also the forwarding value).

Function
REQ-017 The source mux and byte extension SHALL be applied at acceptance; entries store final data, rd, and a write flag.
REQ-018 Write flag SHALL be 0 when in_sel=3 or in_rd=0; such entries still occupy a slot and drain normally.
REQ-019 Storage SHALL be a 2-entry skid buffer with occupancy states EMPTY, ONE, TWO.
REQ-020 Accept = in_valid and in_ready; drain = wb_valid and rf_ready.
REQ-021 in_ready SHALL be a register output, 1 unless state is TWO.
REQ-022 Transitions: EMPTY+accept -> ONE; ONE+accept, no drain -> TWO; ONE+drain, no accept -> EMPTY; ONE+accept+drain -> ONE with new head; TWO+drain -> ONE with skid entry promoted; otherwise hold.
REQ-023 Latency SHALL be 1 cycle from accept to wb_valid when empty; order SHALL be strictly FIFO.
REQ-024 flush SHALL take priority over accept and drain: next state EMPTY, in_ready 1; wb_we SHALL be 0 during the flush cycle.
REQ-025 wb_data, wb_addr SHALL hold their value while wb_valid=0 or rf_ready=0.

Reset
REQ-026 On reset: state EMPTY, wb_valid 0, wb_data 0, wb_addr 0, wb_we 0, in_ready 1 from the next cycle.
REQ-027 Reset SHALL override flush, accept and drain; an entry in flight is dropped.

Configuration
REQ-028 Macro WB_BYTE_LOAD_EN defined: when in_sel=1 and in_byte=1, byte in_blsb of in_dm (0 = bits 7:0) SHALL be extended to DATA_W, sign-extended if in_bsigned else zero-extended.
REQ-029 Macro undefined: in_byte, in_bsigned, in_blsb ignored; DM data passed full width; no extender logic.

Structure
REQ-030 Package mips16_pkg SHALL hold the wb_sel_t encoding (ALU, DM, LINK, NONE) and the occupancy state enum.
REQ-031 Byte extension SHALL be a sub-module wb_load_extender, instantiated only under WB_BYTE_LOAD_EN.

Verification
REQ-032 Reset, then in_valid=1, sel=ALU, in_alu=16'h1234, rd=5, rf_ready=1 -> next cycle wb_valid=1, wb_we=1, wb_addr=5, wb_data=16'h1234.
REQ-033 rf_ready=0, three back-to-back valids 0x0001,0x0002,0x0003 -> in_ready falls after two accepts; on rf_ready=1 writes 0x0001 then 0x0002, third accepted afterwards, order preserved.
REQ-034 sel=ALU, rd=0, data 0xFFFF -> wb_valid=1, wb_we=0; sel=NONE rd=3 -> wb_we=0.
REQ-035 TWO state, flush=1 with in_valid=1 -> next cycle wb_valid=0, in_ready=1, no write strobe; new input not captured.
REQ-036 WB_BYTE_LOAD_EN, in_dm=16'h80F0, byte, signed, blsb=1 -> wb_data=16'hFF80; unsigned blsb=0 -> 16'h00F0; macro off -> 16'h80F0.
REQ-037 Reset asserted in TWO with rf_ready=1 -> no wb_we the following cycle, outputs zero.

Source files
------------

// File: rtl/mips16_pkg.sv
// rtl/mips16_pkg.sv - Shared encodings for the write-back stage.
//
// Contents:
//   wb_sel_t  - result source select (ALU, DM, LINK, NONE)
//   wb_occ_t  - skid buffer occupancy (EMPTY, ONE, TWO)
//   wb_writes - write-flag helper: a result commits only with a real source
//               and a nonzero destination register.
package mips16_pkg;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_DM   = 2'd1,
        SEL_LINK = 2'd2,
        SEL_NONE = 2'd3
    } wb_sel_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } wb_occ_t;

    function automatic logic wb_writes(input wb_sel_t sel, input logic rd_nonzero);
        return (sel != SEL_NONE) && rd_nonzero;
    endfunction

endpackage

// File: rtl/wb_load_extender.sv
// rtl/wb_load_extender.sv - Byte-load extractor and sign/zero extender.
//
// Parameters:
//   DATA_W   - datapath width (even, >= 8)
// Ports:
//   dm       in   DATA_W  raw data-memory word
//   bsigned  in   1       1 = sign-extend the selected byte, 0 = zero-extend
//   blsb     in   1       byte select: 0 = bits 7:0, 1 = bits 15:8
//   data     out  DATA_W  extended byte
module wb_load_extender
    import mips16_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] dm,
    input  logic              bsigned,
    input  logic              blsb,
    output logic [DATA_W-1:0] data
);

    logic [7:0] sel_byte;
    logic       fill;
    logic       unused_dm;

    assign sel_byte  = blsb ? dm[15:8] : dm[7:0];
    assign fill      = bsigned & sel_byte[7];
    assign data      = {{(DATA_W-8){fill}}, sel_byte};

    // Only the low 16 bits can ever be selected; the rest is deliberately ignored.
    assign unused_dm = ^dm;

endmodule

// File: rtl/write_back_stage.sv
// rtl/write_back_stage.sv - Write-back stage with 2-entry skid buffer.
//
// Optional feature: define WB_BYTE_LOAD_EN to enable byte loads (in_byte,
// in_bsigned, in_blsb select and extend one byte of in_dm). When undefined
// those inputs are ignored and DM data passes full width.
//
// Parameters:
//   DATA_W   - datapath width (even, >= 8), default 16
//   RADDR_W  - register-file address width, default 3
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   flush                             discard all buffered write-backs
//   in_valid / in_ready               MEM-stage handshake
//   in_sel                            source select (wb_sel_t encoding)
//   in_alu, in_dm, in_link            candidate results
//   in_rd                             destination register
//   in_byte, in_bsigned, in_blsb      byte-load controls
//   rf_ready                          register-file write port free
//   wb_valid, wb_we, wb_addr, wb_data head entry / write strobe / forwarding value
module write_back_stage
    import mips16_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_sel,
    input  logic [DATA_W-1:0]  in_alu,
    input  logic [DATA_W-1:0]  in_dm,
    input  logic [DATA_W-1:0]  in_link,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_byte,
    input  logic               in_bsigned,
    input  logic               in_blsb,
    input  logic               rf_ready,
    output logic               wb_valid,
    output logic               wb_we,
    output logic [RADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]  wb_data
);

    wb_occ_t            state, state_next;
    logic               ready_q;

    logic [DATA_W-1:0]  head_data, skid_data;
    logic [RADDR_W-1:0] head_rd, skid_rd;
    logic               head_wr, skid_wr;

    logic               accept, drain;
    logic               load_head_in, load_head_skid, load_skid;

    logic [DATA_W-1:0]  dm_data;
    logic [DATA_W-1:0]  new_data;
    logic               new_wr;
    wb_sel_t            sel;

    assign sel = wb_sel_t'(in_sel);

`ifdef WB_BYTE_LOAD_EN
    logic [DATA_W-1:0] ext_data;

    wb_load_extender #(.DATA_W(DATA_W)) u_ext (
        .dm      (in_dm),
        .bsigned (in_bsigned),
        .blsb    (in_blsb),
        .data    (ext_data)
    );

    assign dm_data = in_byte ? ext_data : in_dm;
`else
    logic unused_byte_ctrl;
    assign unused_byte_ctrl = in_byte ^ in_bsigned ^ in_blsb;
    assign dm_data = in_dm;
`endif

    // Source mux resolved at acceptance so entries carry final data only.
    always_comb begin
        new_data = '0;
        case (sel)
            SEL_ALU:  new_data = in_alu;
            SEL_DM:   new_data = dm_data;
            SEL_LINK: new_data = in_link;
            default:  new_data = '0;
        endcase
    end

    assign new_wr = wb_writes(sel, in_rd != '0);

    assign accept = in_valid && ready_q;
    assign drain  = wb_valid && rf_ready;

    // Next-state and buffer-load controls. flush wins over accept/drain.
    always_comb begin
        state_next     = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_next   = OCC_ONE;
                        load_head_in = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && drain) begin
                        load_head_in = 1'b1;
                    end else if (accept) begin
                        state_next = OCC_TWO;
                        load_skid  = 1'b1;
                    end else if (drain) begin
                        state_next = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // ready_q is low here, so no accept can coincide.
                    if (drain) begin
                        state_next     = OCC_ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_next = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= OCC_EMPTY;
            ready_q   <= 1'b1;
            head_data <= '0;
            head_rd   <= '0;
            head_wr   <= 1'b0;
            skid_data <= '0;
            skid_rd   <= '0;
            skid_wr   <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != OCC_TWO);
            if (load_head_in) begin
                head_data <= new_data;
                head_rd   <= in_rd;
                head_wr   <= new_wr;
            end else if (load_head_skid) begin
                head_data <= skid_data;
                head_rd   <= skid_rd;
                head_wr   <= skid_wr;
            end
            if (load_skid) begin
                skid_data <= new_data;
                skid_rd   <= in_rd;
                skid_wr   <= new_wr;
            end
        end
    end

    assign in_ready = ready_q;
    assign wb_valid = (state != OCC_EMPTY);
    // Head registers only move on a load, so data/addr hold while stalled or empty.
    assign wb_addr  = head_rd;
    assign wb_data  = head_data;
    assign wb_we    = wb_valid && rf_ready && head_wr && !flush && !reset;

endmodule

// File: tb/tb_write_back_stage.sv
// tb/tb_write_back_stage.sv - Directed self-checking bench for write_back_stage.
module tb_write_back_stage;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 3;

    logic               clk = 1'b0;
    logic               reset, flush, in_valid, in_ready;
    logic [1:0]         in_sel;
    logic [DATA_W-1:0]  in_alu, in_dm, in_link;
    logic [RADDR_W-1:0] in_rd;
    logic               in_byte, in_bsigned, in_blsb, rf_ready;
    logic               wb_valid, wb_we;
    logic [RADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]  wb_data;

    int checks = 0;
    int errors = 0;

    write_back_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_alu     (in_alu),
        .in_dm      (in_dm),
        .in_link    (in_link),
        .in_rd      (in_rd),
        .in_byte    (in_byte),
        .in_bsigned (in_bsigned),
        .in_blsb    (in_blsb),
        .rf_ready   (rf_ready),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d, input logic [2:0] rd);
        in_valid = v;
        in_sel   = s;
        in_alu   = d;
        in_rd    = rd;
    endtask

`ifdef WB_BYTE_LOAD_EN
    localparam logic [15:0] BYTE_SIGNED_EXP   = 16'hFF80;
    localparam logic [15:0] BYTE_UNSIGNED_EXP = 16'h00F0;
`else
    localparam logic [15:0] BYTE_SIGNED_EXP   = 16'h80F0;
    localparam logic [15:0] BYTE_UNSIGNED_EXP = 16'h80F0;
`endif

    initial begin
        reset = 1'b1; flush = 1'b0; rf_ready = 1'b0;
        in_dm = 16'h0; in_link = 16'h0; in_byte = 1'b0; in_bsigned = 1'b0; in_blsb = 1'b0;
        drive(1'b0, 2'd0, 16'h0, 3'd0);
        step(); step();
        check("rst_valid", wb_valid, 0);
        check("rst_we",    wb_we,    0);
        check("rst_data",  wb_data,  0);
        check("rst_addr",  wb_addr,  0);
        check("rst_ready", in_ready, 1);
        reset = 1'b0;
        step();

        // Basic single-cycle latency
        rf_ready = 1'b1;
        drive(1'b1, 2'd0, 16'h1234, 3'd5);
        step();
        check("lat_valid", wb_valid, 1);
        check("lat_we",    wb_we,    1);
        check("lat_addr",  wb_addr,  5);
        check("lat_data",  wb_data,  16'h1234);
        in_valid = 1'b0;
        step();
        check("drain_valid", wb_valid, 0);
        check("hold_data",   wb_data,  16'h1234);

        // Backpressure: fill to TWO, third blocked, FIFO order
        rf_ready = 1'b0;
        drive(1'b1, 2'd0, 16'h0001, 3'd1);
        step();
        check("bp1_ready", in_ready, 1);
        check("bp1_we",    wb_we,    0);
        drive(1'b1, 2'd0, 16'h0002, 3'd2);
        step();
        check("bp2_ready", in_ready, 0);
        drive(1'b1, 2'd0, 16'h0003, 3'd3);
        step();
        check("bp3_ready", in_ready, 0);
        check("bp3_data",  wb_data,  16'h0001);
        rf_ready = 1'b1;
        #1;
        check("wr1_we",   wb_we,   1);
        check("wr1_addr", wb_addr, 1);
        check("wr1_data", wb_data, 16'h0001);
        step();
        check("wr2_data",  wb_data,  16'h0002);
        check("wr2_we",    wb_we,    1);
        check("wr2_ready", in_ready, 1);
        step();
        check("wr3_data", wb_data, 16'h0003);
        check("wr3_addr", wb_addr, 3);
        in_valid = 1'b0;
        step();
        check("wr_empty", wb_valid, 0);

        // Non-writing entries
        drive(1'b1, 2'd0, 16'hFFFF, 3'd0);
        step();
        check("rd0_valid", wb_valid, 1);
        check("rd0_we",    wb_we,    0);
        check("rd0_data",  wb_data,  16'hFFFF);
        drive(1'b1, 2'd3, 16'h5A5A, 3'd3);
        step();
        check("none_valid", wb_valid, 1);
        check("none_we",    wb_we,    0);
        check("none_addr",  wb_addr,  3);
        in_valid = 1'b0;
        step();

        // Flush in TWO with a new input pending
        rf_ready = 1'b0;
        drive(1'b1, 2'd0, 16'h1111, 3'd1);
        step();
        drive(1'b1, 2'd0, 16'h2222, 3'd2);
        step();
        check("fl_two_ready", in_ready, 0);
        flush = 1'b1; rf_ready = 1'b1;
        drive(1'b1, 2'd0, 16'hAAAA, 3'd4);
        #1;
        check("fl_we", wb_we, 0);
        step();
        check("fl_valid", wb_valid, 0);
        check("fl_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("fl_nocap", wb_valid, 0);

        // DM byte loads
        in_dm = 16'h80F0; in_byte = 1'b1; in_bsigned = 1'b1; in_blsb = 1'b1;
        drive(1'b1, 2'd1, 16'h0, 3'd4);
        step();
        check("byte_signed", wb_data, BYTE_SIGNED_EXP);
        in_bsigned = 1'b0; in_blsb = 1'b0;
        step();
        check("byte_unsigned", wb_data, BYTE_UNSIGNED_EXP);
        in_byte = 1'b0;
        in_link = 16'hBEEF;
        drive(1'b1, 2'd2, 16'h0, 3'd7);
        step();
        check("link_data", wb_data, 16'hBEEF);
        in_valid = 1'b0;
        step();

        // Reset while full
        rf_ready = 1'b0;
        drive(1'b1, 2'd0, 16'h5555, 3'd6);
        step();
        drive(1'b1, 2'd0, 16'h6666, 3'd7);
        step();
        check("rs_two_ready", in_ready, 0);
        reset = 1'b1; rf_ready = 1'b1;
        step();
        check("rs_we",    wb_we,    0);
        check("rs_valid", wb_valid, 0);
        check("rs_data",  wb_data,  0);
        check("rs_addr",  wb_addr,  0);
        check("rs_ready", in_ready, 1);
        reset = 1'b0; in_valid = 1'b0;
        step();
        check("rs_after", wb_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
